// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched
// Round-robin read scheduler for four channel FIFOs. A grant serves up to
// burst_len words from one channel. Each word is read, captured when the
// FIFO acknowledges it, and then held on the output until downstream takes it.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   fifo_empty  per-channel empty flags
//   fifo_valid  per-channel read acknowledge, one cycle after fifo_rd_en
//   fifo_dout   per-channel data, channel n at [n*dta_width +: dta_width]
//   fifo_rd_en  per-channel read enable, one-hot or zero
//   out_data    held data word
//   out_chan    source channel of out_data
//   out_valid   out_data/out_chan hold a word not yet accepted
//   out_ready   downstream accepts the word when high with out_valid
//   out_last    final word of the current grant
//
// state | meaning
// IDLE  | pick the next non-empty channel after last_grant
// RD    | issue one read to the granted channel
// WAIT  | capture the acknowledged word
// HOLD  | present the word until out_ready
module fifo_rr_sched #(
  parameter int unsigned dta_width = 8,
  parameter int unsigned burst_len = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             fifo_empty,
  input  logic [3:0]             fifo_valid,
  input  logic [4*dta_width-1:0] fifo_dout,
  output logic [3:0]             fifo_rd_en,
  output logic [dta_width-1:0]   out_data,
  output logic [1:0]             out_chan,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam logic [4:0] BURST_MAX = 5'(burst_len);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             last_grant_q, last_grant_d;
  logic [4:0]             burst_cnt_q, burst_cnt_d;
  logic [4:0]             burst_cnt_inc;
  logic [dta_width-1:0]   out_data_q, out_data_d;
  logic [1:0]             out_chan_q, out_chan_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;

  logic                   rr_found;
  logic [1:0]             rr_pick;
  logic [1:0]             rr_cand;

  // Search starts one past the last grant; the 4th candidate wraps back to
  // last_grant itself so a lone busy channel can be re-granted.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = 2'd0;
    rr_cand  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = last_grant_q + 2'(i);
      if (!rr_found && !fifo_empty[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  assign burst_cnt_inc = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 5'd1 : burst_cnt_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d     = rr_pick;
          burst_cnt_d = 5'd0;
          state_d     = RD;
        end
      end

      RD: begin
        if (!fifo_empty[grant_q]) begin
          state_d = WAIT;
        end else begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end

      WAIT: begin
        if (fifo_valid[grant_q]) begin
          out_data_d  = fifo_dout[grant_q*dta_width +: dta_width];
          out_chan_d  = grant_q;
          out_valid_d = 1'b1;
          burst_cnt_d = burst_cnt_inc;
          // Empty here already reflects the word just read, so this flags
          // the word that drains the channel.
          out_last_d  = (burst_cnt_inc == BURST_MAX) || fifo_empty[grant_q];
          state_d     = HOLD;
        end else begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if ((burst_cnt_q < BURST_MAX) && !fifo_empty[grant_q]) begin
            state_d = RD;
          end else begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      burst_cnt_q  <= 5'd0;
      out_data_q   <= '0;
      out_chan_q   <= 2'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  // The read strobe is decided in RD itself so a channel that emptied since
  // the grant is never underflowed; gating with rst keeps reads off during reset.
  always_comb begin
    fifo_rd_en = 4'b0000;
    if (rst && (state_q == RD) && !fifo_empty[grant_q]) begin
      fifo_rd_en[grant_q] = 1'b1;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched
// Directed bench: two schedulers (burst_len 4 and 1) driven by a behavioural
// model of four FIFOs each. Stimulus pushes expected words into a scoreboard;
// a monitor pops and compares every word accepted downstream.
module tb_fifo_rr_sched;

  localparam int DW = 8;

  typedef struct {
    int          dut;
    logic [DW-1:0] data;
    logic [1:0]  chan;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out_ready = 1'b0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]      f_empty [2] = '{4'hF, 4'hF};
  logic [3:0]      f_valid [2] = '{4'h0, 4'h0};
  logic [4*DW-1:0] f_dout  [2] = '{'0, '0};
  logic [3:0]      rd_en   [2];
  logic [3:0]      rd_req  [2] = '{4'h0, 4'h0};
  logic [DW-1:0]   o_data  [2];
  logic [1:0]      o_chan  [2];
  logic            o_valid [2];
  logic            o_last  [2];

  logic [DW-1:0] fq [8][$];
  exp_t sb [$];

  int checks = 0;
  int nfail  = 0;

  fifo_rr_sched #(.dta_width(DW), .burst_len(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .fifo_empty(f_empty[0]), .fifo_valid(f_valid[0]), .fifo_dout(f_dout[0]),
    .fifo_rd_en(rd_en[0]),
    .out_data(o_data[0]), .out_chan(o_chan[0]), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_last(o_last[0])
  );

  fifo_rr_sched #(.dta_width(DW), .burst_len(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .fifo_empty(f_empty[1]), .fifo_valid(f_valid[1]), .fifo_dout(f_dout[1]),
    .fifo_rd_en(rd_en[1]),
    .out_data(o_data[1]), .out_chan(o_chan[1]), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_last(o_last[1])
  );

  // Read requests are captured mid-cycle so the FIFO model never races the
  // DUT's own state update at the rising edge.
  always @(negedge clk) begin
    rd_req[0] = rd_en[0];
    rd_req[1] = rd_en[1];
  end

  always @(posedge clk) begin
    logic [3:0]      v;
    logic [3:0]      e;
    logic [4*DW-1:0] dt;
    for (int d = 0; d < 2; d++) begin
      v  = 4'h0;
      e  = 4'h0;
      dt = f_dout[d];
      for (int n = 0; n < 4; n++) begin
        if (rd_req[d][n]) begin
          checks++;
          if (fq[d*4+n].size() > 0) begin
            dt[n*DW +: DW] = fq[d*4+n].pop_front();
            v[n] = 1'b1;
          end else begin
            nfail++;
            $display("FAIL underflow dut%0d ch%0d: read issued with fifo size 0, required no read", d, n);
          end
        end
        e[n] = (fq[d*4+n].size() == 0);
      end
      f_valid[d] <= v;
      f_dout[d]  <= dt;
      f_empty[d] <= e;
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rd_en[d] != 4'b0000 && (o_valid[d] || $countones(rd_en[d]) != 1)) begin
          nfail++;
          $display("FAIL rd_en_rule dut%0d: rd_en=%b out_valid=%b, required one-hot and no read while valid",
                   d, rd_en[d], o_valid[d]);
        end
        if (o_valid[d] && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            nfail++;
            $display("FAIL sb_unexpected dut%0d: got chan=%0d data=%0h last=%0b, required no word",
                     d, o_chan[d], o_data[d], o_last[d]);
          end else begin
            x = sb.pop_front();
            if (x.dut != d || o_data[d] !== x.data || o_chan[d] !== x.chan || o_last[d] !== x.last) begin
              nfail++;
              $display("FAIL sb_word: got dut%0d chan=%0d data=%0h last=%0b, required dut%0d chan=%0d data=%0h last=%0b",
                       d, o_chan[d], o_data[d], o_last[d], x.dut, x.chan, x.data, x.last);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int d, input int ch, input logic [DW-1:0] v);
    fq[d*4+ch].push_back(v);
  endtask

  task automatic exp_word(input int d, input logic [1:0] ch, input logic [DW-1:0] v, input logic last);
    exp_t x;
    x.dut  = d;
    x.chan = ch;
    x.data = v;
    x.last = last;
    sb.push_back(x);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL drain_timeout: %0d words pending, required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en",     32'(rd_en[0]),   32'h0);
    chk("rst_out_valid", 32'(o_valid[0]), 32'h0);
    chk("rst_out_last",  32'(o_last[0]),  32'h0);
    chk("rst_out_chan",  32'(o_chan[0]),  32'h0);
    chk("rst_out_data",  32'(o_data[0]),  32'h0);
    chk("rst_valid_d1",  32'(o_valid[1]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Ch2 with 6 words, burst 4: two grants (4 + 2), plus latency
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push(0, 2, 8'(8'h20 + k));
    exp_word(0, 2'd2, 8'h20, 1'b0);
    exp_word(0, 2'd2, 8'h21, 1'b0);
    exp_word(0, 2'd2, 8'h22, 1'b0);
    exp_word(0, 2'd2, 8'h23, 1'b1);
    exp_word(0, 2'd2, 8'h24, 1'b0);
    exp_word(0, 2'd2, 8'h25, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("lat_rd_en",      32'(rd_en[0]),   32'h4);
    @(negedge clk);
    chk("rd_en_one_cyc",  32'(rd_en[0]),   32'h0);
    chk("lat_valid_early",32'(o_valid[0]), 32'h0);
    @(negedge clk);
    chk("lat_valid",      32'(o_valid[0]), 32'h1);
    @(negedge clk);
    chk("burst_rd_en",    32'(rd_en[0]),   32'h4);
    chk("burst_valid_lo", 32'(o_valid[0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("burst_valid",    32'(o_valid[0]), 32'h1);
    drain(200);

    // Ch3 with 2 words: last on word 2, no underflow read
    @(posedge clk); #1;
    push(0, 3, 8'h30);
    push(0, 3, 8'h31);
    exp_word(0, 2'd3, 8'h30, 1'b0);
    exp_word(0, 2'd3, 8'h31, 1'b1);
    drain(100);

    // Ch1 word held with out_ready low for 10 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(0, 1, 8'h1A);
    exp_word(0, 2'd1, 8'h1A, 1'b1);
    n = 0;
    while (!o_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_seen", 32'(o_valid[0]), 32'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(o_valid[0]), 32'h1);
      chk("hold_data",  32'(o_data[0]),  32'h1A);
      chk("hold_chan",  32'(o_chan[0]),  32'h1);
      chk("hold_rd_en", 32'(rd_en[0]),   32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(100);

    // Ch1 arriving mid-burst on ch0 waits for the grant to finish
    @(posedge clk); #1;
    push(0, 0, 8'h01);
    push(0, 0, 8'h02);
    push(0, 0, 8'h03);
    exp_word(0, 2'd0, 8'h01, 1'b0);
    exp_word(0, 2'd0, 8'h02, 1'b0);
    exp_word(0, 2'd0, 8'h03, 1'b1);
    exp_word(0, 2'd1, 8'h11, 1'b1);
    n = 0;
    while (!o_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_first_seen", 32'(o_valid[0]), 32'h1);
    @(posedge clk); #1;
    push(0, 1, 8'h11);
    drain(200);

    // burst_len 1, all channels busy: grants 0,1,2,3,0
    @(posedge clk); #1;
    push(1, 0, 8'h40);
    push(1, 0, 8'h41);
    push(1, 1, 8'h50);
    push(1, 2, 8'h60);
    push(1, 3, 8'h70);
    exp_word(1, 2'd0, 8'h40, 1'b1);
    exp_word(1, 2'd1, 8'h50, 1'b1);
    exp_word(1, 2'd2, 8'h60, 1'b1);
    exp_word(1, 2'd3, 8'h70, 1'b1);
    exp_word(1, 2'd0, 8'h41, 1'b1);
    drain(200);

    // Reset pulsed in WAIT: word discarded, then ch0 served first
    @(posedge clk); #1;
    push(0, 2, 8'h77);
    push(0, 0, 8'h05);
    n = 0;
    while (!rd_en[0][2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rd_seen", 32'(rd_en[0]), 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_rd_en", 32'(rd_en[0]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst2_out_valid", 32'(o_valid[0]), 32'h0);
    chk("rst2_out_last",  32'(o_last[0]),  32'h0);
    chk("rst2_out_chan",  32'(o_chan[0]),  32'h0);
    chk("rst2_out_data",  32'(o_data[0]),  32'h0);
    chk("rst2_rd_en",     32'(rd_en[0]),   32'h0);
    @(posedge clk); #1;
    exp_word(0, 2'd0, 8'h05, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_rd_ch0", 32'(rd_en[0]), 32'h1);
    drain(100);

    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, nfail);
    $finish;
  end

endmodule
